// File: rtl/clic_pkg.sv
// Shared CLIC constants: virtual-supervisor context sizing.
package clic_pkg;

    // Number of VS contexts a hart can host; context id 0 means "not virtualised".
    localparam int MAX_VSCTXTS = 32;
    localparam int VSID_W      = $clog2(MAX_VSCTXTS + 1);

endpackage : clic_pkg

// File: rtl/clic_irq_if.sv
// Hart-side interrupt presentation bundle: valid/ready handshake, kill path
// and the claim strobe returned towards the source register file.
interface clic_irq_if
    import clic_pkg::*;
#(
    parameter int SRC_W      = 8,
    parameter int INTCTLBITS = 8
);

    logic                  irq_valid_o;
    logic                  irq_ready_i;
    logic [SRC_W-1:0]      irq_id_o;
    logic [INTCTLBITS-1:0] irq_level_o;
    logic [1:0]            irq_priv_o;
    logic [VSID_W-1:0]     irq_vsid_o;
    logic                  irq_shv_o;
    logic                  irq_kill_req_o;
    logic                  irq_kill_ack_i;
    logic                  claim_o;
    logic [SRC_W-1:0]      claim_id_o;

    // Arbiter side.
    modport master (
        output irq_valid_o,
        input  irq_ready_i,
        output irq_id_o,
        output irq_level_o,
        output irq_priv_o,
        output irq_vsid_o,
        output irq_shv_o,
        output irq_kill_req_o,
        input  irq_kill_ack_i,
        output claim_o,
        output claim_id_o
    );

    // Hart / register-file side.
    modport slave (
        input  irq_valid_o,
        output irq_ready_i,
        input  irq_id_o,
        input  irq_level_o,
        input  irq_priv_o,
        input  irq_vsid_o,
        input  irq_shv_o,
        input  irq_kill_req_o,
        output irq_kill_ack_i,
        input  claim_o,
        input  claim_id_o
    );

endinterface : clic_irq_if

// File: rtl/clic_target_arb.sv
// CLIC target arbiter: picks the highest-priority eligible source with a
// max-tree, registers the candidate, presents it to the hart with a kill path
// for preemption/ineligibility, and pulses a claim once the hart accepts.
module clic_target_arb
    import clic_pkg::*;
#(
    parameter int  N_SOURCE   = 256,
    parameter int  INTCTLBITS = 8,
    localparam int SRC_W      = $clog2(N_SOURCE)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_SOURCE-1:0]            ip_i,
    input  logic [N_SOURCE-1:0]            ie_i,
    input  logic [N_SOURCE*INTCTLBITS-1:0] ctl_i,
    input  logic [N_SOURCE*2-1:0]          priv_i,
    input  logic [N_SOURCE*VSID_W-1:0]     vsid_i,
    input  logic [N_SOURCE-1:0]            shv_i,
    input  logic [VSID_W-1:0]              active_vsid_i,
    clic_irq_if.master                     hart
);

    // Leaf count padded to a power of two so the tree is perfectly balanced;
    // padding leaves are never eligible.
    localparam int P     = 1 << SRC_W;
    localparam int NODES = 2 * P - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        KILL    = 2'd2,
        ACK     = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Per-source unpacking and eligibility
    // ------------------------------------------------------------------
    logic [P-1:0]          elig_pad;
    logic [P-1:0]          shv_pad;
    logic [INTCTLBITS-1:0] ctl_arr  [P];
    logic [1:0]            priv_arr [P];
    logic [VSID_W-1:0]     vsid_arr [P];

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_src
            if (gi < N_SOURCE) begin : g_real
                logic [VSID_W-1:0] src_vsid;
                assign src_vsid      = vsid_i[gi*VSID_W +: VSID_W];
                // A virtualised source only competes while its VS context runs.
                assign elig_pad[gi]  = ip_i[gi] & ie_i[gi] &
                                       ((src_vsid == '0) | (src_vsid == active_vsid_i));
                assign ctl_arr[gi]   = ctl_i[gi*INTCTLBITS +: INTCTLBITS];
                assign priv_arr[gi]  = priv_i[gi*2 +: 2];
                assign vsid_arr[gi]  = src_vsid;
                assign shv_pad[gi]   = shv_i[gi];
            end else begin : g_pad
                assign elig_pad[gi]  = 1'b0;
                assign ctl_arr[gi]   = '0;
                assign priv_arr[gi]  = '0;
                assign vsid_arr[gi]  = '0;
                assign shv_pad[gi]   = 1'b0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Max-tree
    // ------------------------------------------------------------------
    logic                  win_valid;
    logic [INTCTLBITS-1:0] win_ctl;
    logic [SRC_W-1:0]      win_id;

    // Heap-ordered tree, leaves at P-1..2P-2; the left child always covers
    // lower ids, so taking it on a tie gives lowest-index-wins.
    always_comb begin : tree
        logic [NODES-1:0]      tv;
        logic [INTCTLBITS-1:0] tc  [NODES];
        logic [SRC_W-1:0]      tid [NODES];
        logic                  take_l;
        tv     = '0;
        take_l = 1'b0;
        for (int i = 0; i < NODES; i++) begin
            tc[i]  = '0;
            tid[i] = '0;
        end
        for (int i = 0; i < P; i++) begin
            tv[P-1+i]  = elig_pad[i];
            tc[P-1+i]  = ctl_arr[i];
            tid[P-1+i] = SRC_W'(i);
        end
        for (int n = P - 2; n >= 0; n--) begin
            take_l = tv[2*n+1] & (~tv[2*n+2] | (tc[2*n+1] >= tc[2*n+2]));
            tv[n]  = tv[2*n+1] | tv[2*n+2];
            tc[n]  = take_l ? tc[2*n+1]  : tc[2*n+2];
            tid[n] = take_l ? tid[2*n+1] : tid[2*n+2];
        end
        win_valid = tv[0];
        win_ctl   = tc[0];
        win_id    = tid[0];
    end

    // ------------------------------------------------------------------
    // Candidate register
    // ------------------------------------------------------------------
    logic                  cand_valid_reg;
    logic [SRC_W-1:0]      cand_id_reg;
    logic [INTCTLBITS-1:0] cand_ctl_reg;
    logic [1:0]            cand_priv_reg;
    logic [VSID_W-1:0]     cand_vsid_reg;
    logic                  cand_shv_reg;

    // Capture the tree result every cycle; fields are zeroed when nothing is
    // eligible so an empty candidate can never look like a preemptor.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cand_valid_reg <= 1'b0;
            cand_id_reg    <= '0;
            cand_ctl_reg   <= '0;
            cand_priv_reg  <= '0;
            cand_vsid_reg  <= '0;
            cand_shv_reg   <= 1'b0;
        end else if (win_valid) begin
            cand_valid_reg <= 1'b1;
            cand_id_reg    <= win_id;
            cand_ctl_reg   <= win_ctl;
            cand_priv_reg  <= priv_arr[win_id];
            cand_vsid_reg  <= vsid_arr[win_id];
            cand_shv_reg   <= shv_pad[win_id];
        end else begin
            cand_valid_reg <= 1'b0;
            cand_id_reg    <= '0;
            cand_ctl_reg   <= '0;
            cand_priv_reg  <= '0;
            cand_vsid_reg  <= '0;
            cand_shv_reg   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Presentation FSM with registered outputs
    // ------------------------------------------------------------------
    state_t                state_reg;
    logic                  irq_valid_reg;
    logic [SRC_W-1:0]      irq_id_reg;
    logic [INTCTLBITS-1:0] irq_level_reg;
    logic [1:0]            irq_priv_reg;
    logic [VSID_W-1:0]     irq_vsid_reg;
    logic                  irq_shv_reg;
    logic                  kill_req_reg;
    logic                  claim_reg;
    logic [SRC_W-1:0]      claim_id_reg;
    logic                  kill_cond;

    // Withdraw when the presented source stopped being eligible (pending or
    // enable dropped, or its VS context is no longer running) or a strictly
    // higher-priority candidate is waiting.
    assign kill_cond = ~elig_pad[irq_id_reg] |
                       (cand_valid_reg & (cand_ctl_reg > irq_level_reg));

    // Handshake sequencing; ready always takes precedence over the kill path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            irq_valid_reg <= 1'b0;
            irq_id_reg    <= '0;
            irq_level_reg <= '0;
            irq_priv_reg  <= '0;
            irq_vsid_reg  <= '0;
            irq_shv_reg   <= 1'b0;
            kill_req_reg  <= 1'b0;
            claim_reg     <= 1'b0;
            claim_id_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cand_valid_reg) begin
                        irq_valid_reg <= 1'b1;
                        irq_id_reg    <= cand_id_reg;
                        irq_level_reg <= cand_ctl_reg;
                        irq_priv_reg  <= cand_priv_reg;
                        irq_vsid_reg  <= cand_vsid_reg;
                        irq_shv_reg   <= cand_shv_reg;
                        state_reg     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (hart.irq_ready_i) begin
                        irq_valid_reg <= 1'b0;
                        claim_reg     <= 1'b1;
                        claim_id_reg  <= irq_id_reg;
                        state_reg     <= ACK;
                    end else if (kill_cond) begin
                        kill_req_reg  <= 1'b1;
                        state_reg     <= KILL;
                    end
                end
                KILL: begin
                    if (hart.irq_ready_i) begin
                        // Hart took it anyway: abandon the kill and claim.
                        irq_valid_reg <= 1'b0;
                        kill_req_reg  <= 1'b0;
                        claim_reg     <= 1'b1;
                        claim_id_reg  <= irq_id_reg;
                        state_reg     <= ACK;
                    end else if (hart.irq_kill_ack_i) begin
                        irq_valid_reg <= 1'b0;
                        kill_req_reg  <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                ACK: begin
                    claim_reg <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    irq_valid_reg <= 1'b0;
                    kill_req_reg  <= 1'b0;
                    claim_reg     <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign hart.irq_valid_o    = irq_valid_reg;
    assign hart.irq_id_o       = irq_id_reg;
    assign hart.irq_level_o    = irq_level_reg;
    assign hart.irq_priv_o     = irq_priv_reg;
    assign hart.irq_vsid_o     = irq_vsid_reg;
    assign hart.irq_shv_o      = irq_shv_reg;
    assign hart.irq_kill_req_o = kill_req_reg;
    assign hart.claim_o        = claim_reg;
    assign hart.claim_id_o     = claim_id_reg;

endmodule : clic_target_arb

// File: doc/clic_target_arb.md
Name: clic_target_arb

Overview:
- Downstream stage of the CLIC interrupt-source register file.
- Each cycle it receives every source's pending/enable/control/privilege/VS-context fields and selects the highest-priority eligible interrupt through a max-tree.
- It presents the winner to the hart over a valid/ready handshake with a kill path, then pulses a claim back to the register file so edge-triggered pending bits are cleared.
- VS-context width and constants come from clic_pkg (VSID_W, MAX_VSCTXTS).

Parameters:
N_SOURCE, 256, number of interrupt sources (>=2)
INTCTLBITS, 8, width of per-source level/priority control field
SRC_W, $clog2(N_SOURCE), source id width (derived, not overridden)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ip_i  in  N_SOURCE  per-source pending
ie_i  in  N_SOURCE  per-source enable
ctl_i  in  N_SOURCE*INTCTLBITS  per-source control (larger = higher priority)
priv_i  in  N_SOURCE*2  per-source target privilege (00 U, 01 S, 11 M)
vsid_i  in  N_SOURCE*VSID_W  per-source VS context; 0 = not virtualised
shv_i  in  N_SOURCE  per-source selective-hardware-vectoring flag
active_vsid_i  in  VSID_W  VS context currently running on the hart
irq_valid_o  out  1  interrupt presented to hart
irq_ready_i  in  1  hart accepts presented interrupt
irq_id_o  out  SRC_W  presented source id
irq_level_o  out  INTCTLBITS  presented control value
irq_priv_o  out  2  presented privilege
irq_vsid_o  out  VSID_W  presented VS context
irq_shv_o  out  1  presented shv flag
irq_kill_req_o  out  1  request to withdraw presented interrupt
irq_kill_ack_i  in  1  hart confirms withdrawal
claim_o  out  1  one-cycle pulse: presented id taken
claim_id_o  out  SRC_W  id being claimed

Behaviour:
- Eligibility: ip_i[i] & ie_i[i] & (vsid_i[i]==0 | vsid_i[i]==active_vsid_i).
- Arbitration is combinational: maximum ctl among eligible sources; ties go to the lowest index. Result (cand_valid, cand_id, cand_ctl plus fields) is registered. Latency from input change to candidate register is 1 cycle.
- Reset: FSM in IDLE; candidate register cleared; all outputs 0.
- FSM states: IDLE, PRESENT, KILL, ACK.
- IDLE:
  - If cand_valid, copy the candidate into the output registers and go to PRESENT. irq_valid_o=1 from the next cycle.
  - Otherwise stay in IDLE.
- PRESENT: irq_valid_o=1 and all irq_* outputs held stable.
  - irq_ready_i=1 -> ACK.
  - Else, if the presented id is no longer eligible, or cand_ctl > irq_level_o strictly -> KILL.
  - ready wins over the kill condition in the same cycle.
- KILL: irq_valid_o=1 and irq_kill_req_o=1, outputs held.
  - irq_ready_i=1 -> ACK (hart took it; the kill is abandoned).
  - Else irq_kill_ack_i=1 -> IDLE; valid and kill_req drop the next cycle.
  - If ready and kill_ack are both 1, ready wins.
- ACK: irq_valid_o=0, claim_o=1 for exactly one cycle, claim_id_o=irq_id_o; then -> IDLE.
- IDLE after ACK or KILL re-evaluates the fresh candidate. The minimum gap between two presentations is one IDLE cycle.
- claim_o is never asserted outside ACK. claim_id_o and irq_* outputs hold their last value when not valid.
- Equal ctl does not preempt; a lower id arriving with equal ctl does not preempt either.
- Asynchronous reset in any state returns to IDLE with outputs 0 immediately. No claim is issued.
- active_vsid_i changing mid-PRESENT makes a mismatched virtual source ineligible -> KILL.

Test Plan:
1. Reset, then ip/ie set on id 5, ctl 0x40, priv 11, vsid 0 -> irq_valid_o rises 2 cycles later with id 5, level 0x40. Ready held 1 -> claim_o pulse with claim_id_o=5 one cycle after the handshake.
2. Ids 3 and 9 both ctl 0x80, with id 7 at ctl 0x20 -> id 3 presented. After its claim and ip[3] cleared, id 9 is presented next.
3. Id 4 (ctl 0x10) presented, ready held 0, then id 12 with ctl 0x90 made pending -> irq_kill_req_o=1. kill_ack pulse -> valid drops; id 12 presented after one IDLE cycle; no claim for id 4.
4. Kill pending on id 4 and irq_ready_i=1 together with irq_kill_ack_i=1 -> ACK taken, claim_o for id 4, kill abandoned.
5. Id 20 with vsid 3 pending, active_vsid_i=2 -> no valid. Set active_vsid_i=3 -> id 20 presented with irq_vsid_o=3. Switch to 1 while presented -> kill_req.
6. rst_ni pulled low during KILL -> all outputs 0 asynchronously. After release, the still-eligible interrupt is re-presented with no claim emitted.
